// File: rtl/au_cmd_issuer.sv
// au_cmd_issuer: host-side sequencer for the 32-bit arithmetic unit.
// Commands are queued in a small FIFO, issued one at a time with operands
// held stable for the unit's latency, and the captured results are handed
// back to the host over a valid/ready response channel.
module au_cmd_issuer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // host command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  // arithmetic unit operand side
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [1:0]       au_op,
  // arithmetic unit result side
  input  logic [WIDTH-1:0] au_s,
  input  logic [WIDTH-1:0] au_hi,
  input  logic [WIDTH-1:0] au_lo,
  input  logic             au_zero,
  // host response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_s,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_zero,
  output logic             rsp_dz,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int EW = 2 + 2 * WIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_C   = LW'(LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // sequencer state
  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_lat_q, op_lat_d;
  logic             bzero_lat_q, bzero_lat_d;

  // operand registers towards the arithmetic unit
  logic [WIDTH-1:0] au_a_q, au_a_d;
  logic [WIDTH-1:0] au_b_q, au_b_d;
  logic [1:0]       au_op_q, au_op_d;

  // response registers towards the host
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
  logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
  logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_dz_q, rsp_dz_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [EW-1:0]    head_w;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  // Ready depends on the registered occupancy only, so the host sees no
  // combinational path from its own valid or from rsp_ready.
  assign cmd_ready  = (count_q < DEPTH_C);
  assign push       = cmd_valid & cmd_ready;
  assign fifo_empty = (count_q == '0);

  assign head_w  = mem_q[rd_ptr_q];
  assign head_op = head_w[EW-1 -: 2];
  assign head_a  = head_w[2*WIDTH-1 -: WIDTH];
  assign head_b  = head_w[WIDTH-1:0];

  // FIFO payload storage; contents need no reset because the pointers and
  // count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // Next-state logic: issue from the FIFO head, count down the unit's
  // latency, capture results and hold them until the host takes them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_lat_d    = op_lat_q;
    bzero_lat_d = bzero_lat_q;
    au_a_d      = au_a_q;
    au_b_d      = au_b_q;
    au_op_d     = au_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_s_d     = rsp_s_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_dz_d    = rsp_dz_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_s_d     = au_s;
          rsp_hi_d    = au_hi;
          rsp_lo_d    = au_lo;
          rsp_zero_d  = au_zero;
          rsp_op_d    = op_lat_q;
          rsp_dz_d    = (op_lat_q == 2'b11) && bzero_lat_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Back-to-back: the next command goes out on the very edge the
          // current response is accepted.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      au_a_d      = head_a;
      au_b_d      = head_b;
      au_op_d     = head_op;
      op_lat_d    = head_op;
      bzero_lat_d = (head_b == '0);
      cnt_d       = LAT_C;
    end
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; an asynchronous reset drops the queue and any
  // in-flight command and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_lat_q    <= '0;
      bzero_lat_q <= 1'b0;
      au_a_q      <= '0;
      au_b_q      <= '0;
      au_op_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_s_q     <= '0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_dz_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_lat_q    <= op_lat_d;
      bzero_lat_q <= bzero_lat_d;
      au_a_q      <= au_a_d;
      au_b_q      <= au_b_d;
      au_op_q     <= au_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_s_q     <= rsp_s_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_dz_q    <= rsp_dz_d;
    end
  end

  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_op     = au_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_dz    = rsp_dz_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_au_cmd_issuer.sv
// tb_au_cmd_issuer: directed and random stimulus for au_cmd_issuer,
// checked against a transaction-level reference model (command queue plus
// issue/due timestamps) and a simple pipelined arithmetic-unit model.
module tb_au_cmd_issuer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int LAT   = 1;
  localparam int LAT3  = 3;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] s;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic [1:0]  op;
    logic        dz;
  } log_t;

  logic        clk;
  logic        rst_n;

  // main instance (LAT=1)
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] au_a, au_b;
  logic [1:0]  au_op;
  logic [31:0] au_s, au_hi, au_lo;
  logic        au_zero;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_s, rsp_hi, rsp_lo;
  logic        rsp_zero, rsp_dz, busy;

  // second instance (LAT=3)
  logic        d3_cmd_valid, d3_cmd_ready;
  logic [1:0]  d3_cmd_op;
  logic [31:0] d3_cmd_a, d3_cmd_b;
  logic [31:0] d3_au_a, d3_au_b;
  logic [1:0]  d3_au_op;
  logic [31:0] d3_au_s, d3_au_hi, d3_au_lo;
  logic        d3_au_zero;
  logic        d3_rsp_valid, d3_rsp_ready;
  logic [1:0]  d3_rsp_op;
  logic [31:0] d3_rsp_s, d3_rsp_hi, d3_rsp_lo;
  logic        d3_rsp_zero, d3_rsp_dz, d3_busy;

  au_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .au_a(au_a), .au_b(au_b), .au_op(au_op),
    .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo), .au_zero(au_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_s(rsp_s), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_zero(rsp_zero), .rsp_dz(rsp_dz), .busy(busy)
  );

  au_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_op(d3_cmd_op),
    .cmd_a(d3_cmd_a), .cmd_b(d3_cmd_b),
    .au_a(d3_au_a), .au_b(d3_au_b), .au_op(d3_au_op),
    .au_s(d3_au_s), .au_hi(d3_au_hi), .au_lo(d3_au_lo), .au_zero(d3_au_zero),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_op(d3_rsp_op),
    .rsp_s(d3_rsp_s), .rsp_hi(d3_rsp_hi), .rsp_lo(d3_rsp_lo),
    .rsp_zero(d3_rsp_zero), .rsp_dz(d3_rsp_dz), .busy(d3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic function of the unit; DIV by zero yields hi=a, lo=all ones.
  function automatic res_t au_func(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    res_t        r;
    logic [63:0] p;
    r = '0;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00: begin r.s = a + b; r.zero = (r.s == 32'd0); end
      2'b01: begin r.s = a - b; r.zero = (r.s == 32'd0); end
      2'b10: begin r.hi = p[63:32]; r.lo = p[31:0]; r.zero = (p == 64'd0); end
      default: begin
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.zero = 1'b0;
        end else begin
          r.hi = a % b; r.lo = a / b; r.zero = (r.lo == 32'd0);
        end
      end
    endcase
    return r;
  endfunction

  // Arithmetic unit models: sample operands each edge, results LAT edges later.
  res_t au_pipe  [LAT];
  res_t au3_pipe [LAT3];
  always @(posedge clk) begin
    au_pipe[0] <= au_func(au_op, au_a, au_b);
    for (int i = 1; i < LAT; i++) au_pipe[i] <= au_pipe[i-1];
    au3_pipe[0] <= au_func(d3_au_op, d3_au_a, d3_au_b);
    for (int i = 1; i < LAT3; i++) au3_pipe[i] <= au3_pipe[i-1];
  end
  assign au_s       = au_pipe[LAT-1].s;
  assign au_hi      = au_pipe[LAT-1].hi;
  assign au_lo      = au_pipe[LAT-1].lo;
  assign au_zero    = au_pipe[LAT-1].zero;
  assign d3_au_s    = au3_pipe[LAT3-1].s;
  assign d3_au_hi   = au3_pipe[LAT3-1].hi;
  assign d3_au_lo   = au3_pipe[LAT3-1].lo;
  assign d3_au_zero = au3_pipe[LAT3-1].zero;

  // Scoreboard counters and reference model state.
  int      n_chk  = 0;
  int      n_fail = 0;
  cmd_t    m_fifo[$];
  cmd_t    m_cur;
  cmd_t    m_au;
  bit      m_infl;
  bit      m_rv;
  longint  m_cyc;
  longint  m_due;
  res_t    m_rsp;
  logic [1:0] m_rsp_op;
  logic    m_rsp_dz;
  log_t    dut_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_cur    = '0;
    m_au     = '0;
    m_infl   = 1'b0;
    m_rv     = 1'b0;
    m_cyc    = 0;
    m_due    = 0;
    m_rsp    = '0;
    m_rsp_op = '0;
    m_rsp_dz = 1'b0;
  endtask

  // One clock edge of the reference: a response is due LAT+1 edges after
  // its command is issued; issue happens when nothing is in flight or on
  // the edge the pending response is accepted.
  task automatic model_step();
    bit do_push;
    bit do_issue;
    do_push  = cmd_valid && (m_fifo.size() < DEPTH);
    do_issue = 1'b0;
    if (m_rv) begin
      if (rsp_ready) begin
        m_rv     = 1'b0;
        do_issue = (m_fifo.size() != 0);
      end
    end else if (m_infl) begin
      if (m_cyc == m_due) begin
        m_rsp    = au_func(m_cur.op, m_cur.a, m_cur.b);
        m_rsp_op = m_cur.op;
        m_rsp_dz = (m_cur.op == 2'b11) && (m_cur.b == 32'd0);
        m_rv     = 1'b1;
        m_infl   = 1'b0;
      end
    end else begin
      do_issue = (m_fifo.size() != 0);
    end
    if (do_issue) begin
      m_cur  = m_fifo.pop_front();
      m_au   = m_cur;
      m_infl = 1'b1;
      m_due  = m_cyc + LAT + 1;
    end
    if (do_push) m_fifo.push_back({cmd_op, cmd_a, cmd_b});
    m_cyc++;
  endtask

  task automatic check_all();
    chk("cmd_ready", cmd_ready, (m_fifo.size() < DEPTH));
    chk("busy", busy, (m_fifo.size() != 0) || m_infl || m_rv);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("au_a", au_a, m_au.a);
    chk("au_b", au_b, m_au.b);
    chk("au_op", au_op, m_au.op);
    chk("rsp_op", rsp_op, m_rsp_op);
    chk("rsp_s", rsp_s, m_rsp.s);
    chk("rsp_hi", rsp_hi, m_rsp.hi);
    chk("rsp_lo", rsp_lo, m_rsp.lo);
    chk("rsp_zero", rsp_zero, m_rsp.zero);
    chk("rsp_dz", rsp_dz, m_rsp_dz);
  endtask

  // Advance one cycle: log any response handshake, step the model at the
  // edge, then compare everything at the following falling edge.
  task automatic tick();
    log_t e;
    @(posedge clk);
    if (rsp_valid && rsp_ready) begin
      e.s = rsp_s; e.hi = rsp_hi; e.lo = rsp_lo; e.zero = rsp_zero;
      e.op = rsp_op; e.dz = rsp_dz;
      dut_log.push_back(e);
      $display("rsp %0d: op=%0d s=%08h hi=%08h lo=%08h zero=%0b dz=%0b",
               dut_log.size() - 1, rsp_op, rsp_s, rsp_hi, rsp_lo, rsp_zero, rsp_dz);
    end
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    bit rdy;
    ok = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      rdy = cmd_ready;
      tick();
      if (rdy) begin ok = 1'b1; break; end
    end
    chk("send_accepted", ok, 1'b1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int target);
    int k;
    k = 0;
    while (dut_log.size() < target && k < 200) begin
      tick();
      k++;
    end
    chk(tag, dut_log.size(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int lat;
    bit seen;
    logic [31:0] snap_s;
    logic [31:0] snap_a;

    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 1;
    d3_cmd_valid = 0; d3_cmd_op = 0; d3_cmd_a = 0; d3_cmd_b = 0; d3_rsp_ready = 1;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_au_a", au_a, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst3_busy", d3_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_cmd_ready", cmd_ready, 1);

    // Single ADD: operands one edge after handshake, response three edges after.
    rsp_ready = 1;
    cmd_op = 2'b00; cmd_a = 5; cmd_b = 7; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    tick();
    chk("t1_au_a", au_a, 5);
    chk("t1_au_b", au_b, 7);
    chk("t1_au_op", au_op, 0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    chk("t1_latency", lat, 3);
    chk("t1_rsp_s", rsp_s, 12);
    chk("t1_rsp_op", rsp_op, 0);
    tick();

    // Back-to-back with valid held high.
    b0 = dut_log.size();
    send(2'b10, 3, 4);
    send(2'b11, 100, 7);
    send(2'b01, 1, 2);
    drain("t2_drain", b0 + 3);
    chk("t2_mult_hi", dut_log[b0].hi, 0);
    chk("t2_mult_lo", dut_log[b0].lo, 12);
    chk("t2_div_hi", dut_log[b0+1].hi, 2);
    chk("t2_div_lo", dut_log[b0+1].lo, 14);
    chk("t2_sub_s", dut_log[b0+2].s, 32'hFFFF_FFFF);

    // Backpressure: hold the first response for five cycles.
    rsp_ready = 0;
    b0 = dut_log.size();
    send(2'b00, 10, 20);
    send(2'b01, 50, 8);
    send(2'b10, 6, 7);
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    chk("t3_rsp_valid", rsp_valid, 1);
    snap_s = rsp_s;
    snap_a = au_a;
    repeat (5) begin
      tick();
      chk("t3_rsp_s_hold", rsp_s, snap_s);
      chk("t3_au_a_hold", au_a, snap_a);
    end
    chk("t3_cmd_ready_full", cmd_ready, 0);
    rsp_ready = 1;
    drain("t3_drain", b0 + 3);
    chk("t3_first", dut_log[b0].s, 30);
    chk("t3_second", dut_log[b0+1].s, 42);
    chk("t3_third", dut_log[b0+2].lo, 42);

    // Divide by zero flag and a zero-operand ADD.
    b0 = dut_log.size();
    send(2'b11, 9, 0);
    send(2'b00, 0, 0);
    drain("t4_drain", b0 + 2);
    chk("t4_dz", dut_log[b0].dz, 1);
    chk("t4_op", dut_log[b0].op, 3);
    chk("t4_hi", dut_log[b0].hi, 9);
    chk("t4_lo", dut_log[b0].lo, 32'hFFFF_FFFF);
    chk("t4_add_dz", dut_log[b0+1].dz, 0);
    chk("t4_add_zero", dut_log[b0+1].zero, 1);

    // Reset while waiting on the unit with one command queued.
    send(2'b00, 2, 3);
    send(2'b01, 5, 1);
    chk("t5_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_au_a", au_a, 0);
    chk("t5_au_op", au_op, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_s", rsp_s, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_busy_after", busy, 0);
    chk("t5_ready_after", cmd_ready, 1);
    b0 = dut_log.size();
    seen = 0;
    repeat (8) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    chk("t5_no_rsp", seen, 0);
    chk("t5_no_handshake", dut_log.size(), b0);

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      cmd_b     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 0;
    rsp_ready = 1;
    lat = 0;
    while (busy && lat < 100) begin tick(); lat++; end
    chk("t6_idle", busy, 0);

    // LAT=3 instance: operands held through capture, response after 5 edges.
    chk("t7_ready", d3_cmd_ready, 1);
    d3_cmd_op = 2'b00; d3_cmd_a = 1; d3_cmd_b = 1; d3_cmd_valid = 1;
    tick();
    d3_cmd_valid = 0;
    seen = 0;
    lat = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e <= 5) begin
        chk("t7_au_a", d3_au_a, 1);
        chk("t7_au_b", d3_au_b, 1);
        chk("t7_au_op", d3_au_op, 0);
      end
      if (!seen && d3_rsp_valid) begin
        seen = 1;
        lat  = e;
        chk("t7_rsp_s", d3_rsp_s, 2);
      end
    end
    chk("t7_latency", lat, 5);
    chk("t7_idle", d3_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
